// File: rtl/cpu_hazard_pkg.sv
// Shared encodings, record type and default widths for the D-stage hazard/forwarding unit.
package cpu_hazard_pkg;

  localparam int NUM_RD_DEF = 2;
  localparam int DEPTH_DEF  = 3;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int T_W_DEF    = 2;
  localparam int SEL_BITS   = 3;

  localparam logic [SEL_BITS-1:0] SEL_RF = 3'd0;
  localparam logic [SEL_BITS-1:0] SEL_E  = 3'd1;
  localparam logic [SEL_BITS-1:0] SEL_M  = 3'd2;
  localparam logic [SEL_BITS-1:0] SEL_W  = 3'd3;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [T_W_DEF-1:0]    tnew;
  } stage_rec_t;

endpackage

// File: rtl/hazard_fwd_port.sv
// One read port: youngest-match search over the stage records, giving hazard and selected operand.
module hazard_fwd_port
  import cpu_hazard_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int T_W    = T_W_DEF
) (
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [T_W-1:0]          tuse,
  input  logic [DATA_W-1:0]       rf_data,
  input  logic [DEPTH-1:0]        rec_live,
  input  logic [DEPTH*ADDR_W-1:0] rec_addr,
  input  logic [DEPTH*T_W-1:0]    rec_tnew,
  input  logic [DEPTH*DATA_W-1:0] tap_data,
  output logic                    hazard,
  output logic [DATA_W-1:0]       data,
  output logic [SEL_BITS-1:0]     sel
);

  // Walk from oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    hazard = 1'b0;
    data   = rf_data;
    sel    = SEL_RF;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rec_live[k] && (rec_addr[k*ADDR_W +: ADDR_W] == rd_addr)) begin
        hazard = (rec_tnew[k*T_W +: T_W] > tuse);
        data   = tap_data[k*DATA_W +: DATA_W];
        sel    = SEL_E + SEL_BITS'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// D-stage hazard detection and operand forwarding: tracks in-flight writers per stage and
// resolves stall plus per-port forwarding source.
module hazard_fwd_unit
  import cpu_hazard_pkg::*;
#(
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int T_W    = T_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       d_valid,
  input  logic [NUM_RD*ADDR_W-1:0]   d_rd_addr,
  input  logic [NUM_RD*T_W-1:0]      d_tuse,
  input  logic [NUM_RD*DATA_W-1:0]   d_rf_data,
  input  logic                       d_wr_en,
  input  logic [ADDR_W-1:0]          d_wr_addr,
  input  logic [T_W-1:0]             d_tnew,
  input  logic                       ext_stall,
  input  logic [DEPTH*DATA_W-1:0]    tap_data,
  output logic                       stall,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data,
  output logic [NUM_RD*SEL_BITS-1:0] fwd_sel
);

  logic [DEPTH-1:0]        rec_valid;
  logic [DEPTH*ADDR_W-1:0] rec_addr;
  logic [DEPTH*T_W-1:0]    rec_tnew;
  logic [DEPTH-1:0]        rec_live;
  logic [NUM_RD-1:0]       port_hazard;

  // Writes to $0 are discarded by the GRF, so such records never match.
  for (genvar k = 0; k < DEPTH; k++) begin : g_live
    assign rec_live[k] = rec_valid[k] && (rec_addr[k*ADDR_W +: ADDR_W] != '0);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    hazard_fwd_port #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .T_W    (T_W)
    ) u_port (
      .rd_addr  (d_rd_addr[i*ADDR_W +: ADDR_W]),
      .tuse     (d_tuse[i*T_W +: T_W]),
      .rf_data  (d_rf_data[i*DATA_W +: DATA_W]),
      .rec_live (rec_live),
      .rec_addr (rec_addr),
      .rec_tnew (rec_tnew),
      .tap_data (tap_data),
      .hazard   (port_hazard[i]),
      .data     (fwd_data[i*DATA_W +: DATA_W]),
      .sel      (fwd_sel[i*SEL_BITS +: SEL_BITS])
    );
  end

  assign stall = ext_stall | (|port_hazard);

  // Downstream stages always advance; a stalled D injects a bubble into E.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_valid <= '0;
      rec_addr  <= '0;
      rec_tnew  <= '0;
    end else begin
      rec_valid[0]          <= d_valid & d_wr_en & ~stall;
      rec_addr[0 +: ADDR_W] <= d_wr_addr;
      rec_tnew[0 +: T_W]    <= d_tnew;
      for (int k = 1; k < DEPTH; k++) begin
        rec_valid[k]                <= rec_valid[k-1];
        rec_addr[k*ADDR_W +: ADDR_W] <= rec_addr[(k-1)*ADDR_W +: ADDR_W];
        rec_tnew[k*T_W +: T_W]      <= (rec_tnew[(k-1)*T_W +: T_W] == '0) ? '0
                                       : rec_tnew[(k-1)*T_W +: T_W] - T_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed plus randomized checks of hazard_fwd_unit against an age-based model of in-flight writers.
module tb_hazard_fwd_unit;
  import cpu_hazard_pkg::*;

  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int T_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      d_valid;
  logic [NUM_RD*ADDR_W-1:0]  d_rd_addr;
  logic [NUM_RD*T_W-1:0]     d_tuse;
  logic [NUM_RD*DATA_W-1:0]  d_rf_data;
  logic                      d_wr_en;
  logic [ADDR_W-1:0]         d_wr_addr;
  logic [T_W-1:0]            d_tnew;
  logic                      ext_stall;
  logic [DEPTH*DATA_W-1:0]   tap_data;
  logic                      stall;
  logic [NUM_RD*DATA_W-1:0]  fwd_data;
  logic [NUM_RD*3-1:0]       fwd_sel;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NUM_RD(NUM_RD), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .T_W(T_W)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rd_addr(d_rd_addr), .d_tuse(d_tuse),
    .d_rf_data(d_rf_data), .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .ext_stall(ext_stall), .tap_data(tap_data), .stall(stall), .fwd_data(fwd_data),
    .fwd_sel(fwd_sel)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Each in-flight writer: cycle it entered E, destination, Tnew on entry.
  int q_enter[$];
  int q_addr[$];
  int q_tnew[$];

  logic        exp_stall;
  logic [2:0]  exp_sel[NUM_RD];
  logic [31:0] exp_data[NUM_RD];
  bit          exp_known[NUM_RD];

  task automatic model_eval();
    exp_stall = ext_stall;
    for (int i = 0; i < NUM_RD; i++) begin
      int a;
      int tu;
      int best;
      int best_t;
      a      = int'(d_rd_addr[i*ADDR_W +: ADDR_W]);
      tu     = int'(d_tuse[i*T_W +: T_W]);
      best   = -1;
      best_t = 0;
      for (int j = 0; j < q_enter.size(); j++) begin
        int age;
        age = cyc - q_enter[j];
        if (age >= 0 && age < DEPTH && q_addr[j] != 0 && q_addr[j] == a &&
            (best < 0 || age < best)) begin
          best   = age;
          best_t = (q_tnew[j] > age) ? q_tnew[j] - age : 0;
        end
      end
      if (best >= 0 && best_t > tu) exp_stall = 1'b1;
      exp_known[i] = (best < 0) || (best_t == 0);
      exp_sel[i]   = (best < 0) ? 3'd0 : 3'(best + 1);
      exp_data[i]  = (best < 0) ? d_rf_data[i*DATA_W +: DATA_W] : tap_data[best*DATA_W +: DATA_W];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    #1;
    model_eval();
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    for (int i = 0; i < NUM_RD; i++) begin
      if (exp_known[i]) begin
        check($sformatf("%s_sel%0d", tag, i), 32'(fwd_sel[i*3 +: 3]), 32'(exp_sel[i]));
        check($sformatf("%s_data%0d", tag, i), fwd_data[i*DATA_W +: DATA_W], exp_data[i]);
      end
    end
  endtask

  task automatic tick();
    bit commit;
    int wa;
    int wt;
    model_eval();
    commit = d_valid && d_wr_en && !exp_stall;
    wa     = int'(d_wr_addr);
    wt     = int'(d_tnew);
    @(posedge clk);
    if (!reset) begin
      q_enter.delete(); q_addr.delete(); q_tnew.delete();
    end else if (commit) begin
      q_enter.push_back(cyc + 1); q_addr.push_back(wa); q_tnew.push_back(wt);
    end
    cyc++;
    for (int j = q_enter.size() - 1; j >= 0; j--) begin
      if (cyc - q_enter[j] >= DEPTH) begin
        q_enter.delete(j); q_addr.delete(j); q_tnew.delete(j);
      end
    end
    #2;
  endtask

  task automatic idle();
    d_valid = 1'b0; d_wr_en = 1'b0; d_wr_addr = '0; d_tnew = '0;
    d_rd_addr = '0; d_tuse = '0; ext_stall = 1'b0;
  endtask

  function automatic logic [4:0] pick_addr();
    int r;
    r = $urandom_range(0, 4);
    return (r == 0) ? 5'd0 : 5'(7 + r);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    d_rf_data = {32'h0000_0066, 32'h0000_0055};
    tap_data  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    tick(); tick();
    reset = 1'b1;

    // Empty pipe after reset.
    d_rd_addr = {5'd6, 5'd5};
    check_model("rst");
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(fwd_sel), 32'd0);
    check("rst_data", fwd_data[31:0], 32'h55);
    tick();

    // lw $8, tnew=2, followed by a tuse=0 reader: two stall cycles, then W forwarding.
    idle(); d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd8; d_tnew = 2'd2;
    check_model("lw_in"); tick();
    idle(); d_valid = 1'b1; d_rd_addr = {5'd1, 5'd8};
    check_model("lw_s1"); check("lw_s1_stall", 32'(stall), 32'd1); tick();
    check_model("lw_s2"); check("lw_s2_stall", 32'(stall), 32'd1); tick();
    check_model("lw_go");
    check("lw_go_stall", 32'(stall), 32'd0);
    check("lw_go_sel", 32'(fwd_sel[2:0]), 32'(SEL_W));
    check("lw_go_data", fwd_data[31:0], 32'h3333_0003);
    tick();

    // add $9, tnew=1, reader with tuse=1: no stall; one cycle later M supplies it.
    idle(); d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd9; d_tnew = 2'd1;
    check_model("add_in"); tick();
    idle(); d_valid = 1'b1; d_rd_addr = {5'd0, 5'd9}; d_tuse = {2'd0, 2'd1};
    check_model("add_r1"); check("add_r1_stall", 32'(stall), 32'd0); tick();
    d_tuse = '0;
    check_model("add_r2");
    check("add_r2_sel", 32'(fwd_sel[2:0]), 32'(SEL_M));
    check("add_r2_data", fwd_data[31:0], 32'h2222_0002);
    tick();

    // $10 in both E and W: E wins.
    idle(); d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd10; d_tnew = 2'd0;
    tick();
    idle(); tick();
    d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd10; d_tnew = 2'd0;
    tick();
    idle(); d_valid = 1'b1; d_rd_addr = {5'd0, 5'd10};
    tap_data = {32'h0000_5555, 32'h2222_0002, 32'h0000_AAAA};
    check_model("ew");
    check("ew_sel", 32'(fwd_sel[2:0]), 32'(SEL_E));
    check("ew_data", fwd_data[31:0], 32'h0000_AAAA);
    tick();

    // Writer to $0 never causes a hazard.
    idle(); d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd0; d_tnew = 2'd2;
    tick();
    idle(); d_valid = 1'b1; d_rd_addr = {5'd0, 5'd0};
    check_model("r0");
    check("r0_stall", 32'(stall), 32'd0);
    check("r0_sel", 32'(fwd_sel), 32'd0);
    tick();

    // External stall with an empty pipe: bubbles enter E, so $11 is never recorded.
    idle(); tick(); tick(); tick();
    for (int n = 0; n < 3; n++) begin
      ext_stall = 1'b1; d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd11; d_tnew = 2'd1;
      check_model("ext");
      check($sformatf("ext%0d_stall", n), 32'(stall), 32'd1);
      tick();
    end
    idle(); d_valid = 1'b1; d_rd_addr = {5'd0, 5'd11};
    check_model("ext_after");
    check("ext_bubble_stall", 32'(stall), 32'd0);
    check("ext_bubble_sel", 32'(fwd_sel[2:0]), 32'd0);
    tick();

    // Reset in the middle of a load-use stall.
    idle(); d_valid = 1'b1; d_wr_en = 1'b1; d_wr_addr = 5'd12; d_tnew = 2'd2;
    tick();
    idle(); d_valid = 1'b1; d_rd_addr = {5'd0, 5'd12};
    check_model("rh"); check("rh_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_model("rh_after");
    check("rh_after_stall", 32'(stall), 32'd0);
    check("rh_after_sel", 32'(fwd_sel[2:0]), 32'd0);
    check("rh_after_data", fwd_data[31:0], 32'h55);
    tick();

    // Randomized traffic over a small register set to provoke overlaps.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 63) != 0);
      d_valid   = ($urandom_range(0, 3) != 0);
      d_wr_en   = 1'($urandom);
      d_wr_addr = pick_addr();
      d_tnew    = 2'($urandom_range(0, 3));
      ext_stall = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NUM_RD; i++) begin
        d_rd_addr[i*ADDR_W +: ADDR_W] = pick_addr();
        d_tuse[i*T_W +: T_W]          = 2'($urandom_range(0, 3));
        d_rf_data[i*DATA_W +: DATA_W] = $urandom();
      end
      tap_data = {$urandom(), $urandom(), $urandom()};
      check_model("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
